// File: rtl/counter_dispatch_pkg.sv
// Shared constants and slot state encoding for the counter dispatcher.
package counter_dispatch_pkg;

    localparam int unsigned DT_SZ_DEF = 4;
    localparam int unsigned NCNT_MAX  = 4;
    localparam int unsigned IW        = $clog2(NCNT_MAX);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } slot_state_t;

endpackage

// File: rtl/counter_slot.sv
// One service counter: idle/serve FSM with a tick-driven countdown.
module counter_slot
    import counter_dispatch_pkg::*;
#(
    parameter int unsigned DT_SZ = DT_SZ_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    input  logic             load,
    input  logic [DT_SZ-1:0] load_num,
    input  logic [DT_SZ-1:0] load_time,
    output logic             busy,
    output logic [DT_SZ-1:0] num,
    output logic [DT_SZ-1:0] rem,
    output logic             done,
    output logic             fin_c
);

    slot_state_t      state, state_n;
    logic [DT_SZ-1:0] num_n, rem_n;

    // State, customer and countdown registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            num   <= '0;
            rem   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            num   <= num_n;
            rem   <= rem_n;
            done  <= fin_c;
        end
    end

    // Next state: load when idle, count down on enabled ticks while serving
    always_comb begin
        state_n = state;
        num_n   = num;
        rem_n   = rem;
        fin_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_n = ST_SERVE;
                    num_n   = load_num;
                    // a zero service time still occupies the counter for one tick
                    rem_n   = (load_time == '0) ? DT_SZ'(1) : load_time;
                end
            end
            ST_SERVE: begin
                if (en && tick) begin
                    if (rem == DT_SZ'(1)) begin
                        state_n = ST_IDLE;
                        rem_n   = '0;
                        fin_c   = 1'b1;
                    end else begin
                        rem_n = rem - DT_SZ'(1);
                    end
                end
            end
        endcase
    end

    assign busy = (state == ST_SERVE);

endmodule

// File: rtl/counter_dispatch.sv
// Round-robin dispatcher feeding customers from a FIFO to NCNT service counters.
module counter_dispatch
    import counter_dispatch_pkg::*;
#(
    parameter int unsigned NCNT  = 2,
    parameter int unsigned DT_SZ = DT_SZ_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  tick,
    input  logic                  q_empty,
    input  logic [DT_SZ-1:0]      q_num,
    input  logic [DT_SZ-1:0]      q_time,
    output logic                  q_re,
    output logic [NCNT-1:0]       busy,
    output logic [NCNT*DT_SZ-1:0] cnt_num,
    output logic [NCNT*DT_SZ-1:0] cnt_rem,
    output logic                  asg_v,
    output logic [IW-1:0]         asg_id,
    output logic [NCNT-1:0]       done,
    output logic [7:0]            served
);

    logic [IW-1:0]   rr, sel;
    logic [NCNT-1:0] load, fin_c;
    logic            found;
    logic [7:0]      served_n;
    int              best_d, d, fin_cnt, sum;

    // Pick the idle counter closest at-or-after the round-robin pointer
    always_comb begin
        sel    = rr;
        best_d = int'(NCNT);
        d      = 0;
        for (int j = 0; j < int'(NCNT); j++) begin
            d = j - int'(rr);
            if (d < 0) d = d + int'(NCNT);
            if (!busy[j] && d < best_d) begin
                best_d = d;
                sel    = IW'(j);
            end
        end
        found = (best_d < int'(NCNT));
    end

    // FIFO pop and one-hot load to the selected counter
    always_comb begin
        q_re = ~rst & en & ~q_empty & found;
        load = '0;
        for (int k = 0; k < int'(NCNT); k++) begin
            load[k] = q_re && (int'(sel) == k);
        end
    end

    // Saturating count of completions on this edge
    always_comb begin
        fin_cnt = 0;
        for (int k = 0; k < int'(NCNT); k++) begin
            if (fin_c[k]) fin_cnt = fin_cnt + 1;
        end
        sum      = int'(served) + fin_cnt;
        served_n = (sum > 255) ? 8'hFF : 8'(sum);
    end

    // Pointer, assignment pulse and statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr     <= '0;
            asg_v  <= 1'b0;
            asg_id <= '0;
            served <= '0;
        end else begin
            asg_v  <= q_re;
            served <= served_n;
            if (q_re) begin
                asg_id <= sel;
                rr     <= (int'(sel) == int'(NCNT) - 1) ? '0 : sel + IW'(1);
            end
        end
    end

    for (genvar k = 0; k < int'(NCNT); k++) begin : g_slot
        counter_slot #(.DT_SZ(DT_SZ)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .tick      (tick),
            .load      (load[k]),
            .load_num  (q_num),
            .load_time (q_time),
            .busy      (busy[k]),
            .num       (cnt_num[k*DT_SZ +: DT_SZ]),
            .rem       (cnt_rem[k*DT_SZ +: DT_SZ]),
            .done      (done[k]),
            .fin_c     (fin_c[k])
        );
    end

endmodule

// File: tb/tb_counter_dispatch.sv
// Directed table-driven bench for counter_dispatch with NCNT=2, DT_SZ=4.
module tb_counter_dispatch;

    logic       clk = 1'b0;
    logic       rst, en, tick, q_empty;
    logic [3:0] q_num, q_time;
    logic       q_re, asg_v;
    logic [1:0] busy, done, asg_id;
    logic [7:0] cnt_num, cnt_rem, served;

    int n_chk  = 0;
    int n_fail = 0;

    counter_dispatch #(.NCNT(2), .DT_SZ(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .tick    (tick),
        .q_empty (q_empty),
        .q_num   (q_num),
        .q_time  (q_time),
        .q_re    (q_re),
        .busy    (busy),
        .cnt_num (cnt_num),
        .cnt_rem (cnt_rem),
        .asg_v   (asg_v),
        .asg_id  (asg_id),
        .done    (done),
        .served  (served)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, tick, qe;
        logic [3:0] qn, qt;
        logic       qre;
        logic [1:0] busy;
        logic [7:0] num, rem;
        logic       av;
        logic [1:0] aid, done;
        logic [7:0] served;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(input logic e, t, qe, input logic [3:0] qn, qt,
                                input logic qre, input logic [1:0] b,
                                input logic [7:0] num, rem, input logic av,
                                input logic [1:0] aid, dn, input logic [7:0] sv);
        vec_t v;
        v.en = e; v.tick = t; v.qe = qe; v.qn = qn; v.qt = qt; v.qre = qre;
        v.busy = b; v.num = num; v.rem = rem; v.av = av; v.aid = aid;
        v.done = dn; v.served = sv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check q_re before the edge, land 1 time unit past the edge
    task automatic run(input string nm, input logic e, t, qe, input logic [3:0] qn, qt,
                       input logic exp_qre);
        en = e; tick = t; q_empty = qe; q_num = qn; q_time = qt;
        #1;
        chk({nm, " q_re"}, 32'(q_re), 32'(exp_qre));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; tick = 1'b0; q_empty = 1'b0; q_num = 4'h0; q_time = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vt[0]  = mk(1'b1,1'b0,1'b0,4'h5,4'h3, 1'b1, 2'b01, 8'h05, 8'h03, 1'b1, 2'd0, 2'b00, 8'd0);
        vt[1]  = mk(1'b1,1'b1,1'b1,4'h0,4'h0, 1'b0, 2'b01, 8'h05, 8'h02, 1'b0, 2'd0, 2'b00, 8'd0);
        vt[2]  = mk(1'b1,1'b1,1'b1,4'h0,4'h0, 1'b0, 2'b01, 8'h05, 8'h01, 1'b0, 2'd0, 2'b00, 8'd0);
        vt[3]  = mk(1'b1,1'b1,1'b1,4'h0,4'h0, 1'b0, 2'b00, 8'h05, 8'h00, 1'b0, 2'd0, 2'b01, 8'd1);
        vt[4]  = mk(1'b1,1'b0,1'b1,4'h0,4'h0, 1'b0, 2'b00, 8'h05, 8'h00, 1'b0, 2'd0, 2'b00, 8'd1);
        vt[5]  = mk(1'b1,1'b0,1'b0,4'h7,4'h0, 1'b1, 2'b10, 8'h75, 8'h10, 1'b1, 2'd1, 2'b00, 8'd1);
        vt[6]  = mk(1'b1,1'b1,1'b0,4'h9,4'h2, 1'b1, 2'b01, 8'h79, 8'h02, 1'b1, 2'd0, 2'b10, 8'd2);
        vt[7]  = mk(1'b0,1'b1,1'b0,4'h3,4'h1, 1'b0, 2'b01, 8'h79, 8'h02, 1'b0, 2'd0, 2'b00, 8'd2);
        vt[8]  = mk(1'b0,1'b1,1'b1,4'h0,4'h0, 1'b0, 2'b01, 8'h79, 8'h02, 1'b0, 2'd0, 2'b00, 8'd2);
        vt[9]  = mk(1'b1,1'b0,1'b0,4'h3,4'h1, 1'b1, 2'b11, 8'h39, 8'h12, 1'b1, 2'd1, 2'b00, 8'd2);
        vt[10] = mk(1'b1,1'b0,1'b0,4'h4,4'h5, 1'b0, 2'b11, 8'h39, 8'h12, 1'b0, 2'd1, 2'b00, 8'd2);
        vt[11] = mk(1'b1,1'b1,1'b0,4'h4,4'h5, 1'b0, 2'b01, 8'h39, 8'h01, 1'b0, 2'd1, 2'b10, 8'd3);
        vt[12] = mk(1'b1,1'b0,1'b0,4'h4,4'h5, 1'b1, 2'b11, 8'h49, 8'h51, 1'b1, 2'd1, 2'b00, 8'd3);
        vt[13] = mk(1'b1,1'b1,1'b1,4'h0,4'h0, 1'b0, 2'b10, 8'h49, 8'h40, 1'b0, 2'd1, 2'b01, 8'd4);

        // Reset state; q_re must stay low while reset is held even with work pending
        rst = 1'b1; en = 1'b1; tick = 1'b0; q_empty = 1'b0; q_num = 4'h5; q_time = 4'h3;
        #1;
        chk("rst q_re", 32'(q_re), 32'(1'b0));
        @(posedge clk);
        #1;
        chk("rst busy",   32'(busy),    32'(2'b00));
        chk("rst num",    32'(cnt_num), 32'(8'h00));
        chk("rst rem",    32'(cnt_rem), 32'(8'h00));
        chk("rst asg_v",  32'(asg_v),   32'(1'b0));
        chk("rst asg_id", 32'(asg_id),  32'(2'd0));
        chk("rst done",   32'(done),    32'(2'b00));
        chk("rst served", 32'(served),  32'(8'd0));
        rst = 1'b0;

        // Table: load, countdown, zero service time, round-robin, en freeze
        for (int i = 0; i < 14; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            run(nm, vt[i].en, vt[i].tick, vt[i].qe, vt[i].qn, vt[i].qt, vt[i].qre);
            chk({nm, " busy"},   32'(busy),    32'(vt[i].busy));
            chk({nm, " num"},    32'(cnt_num), 32'(vt[i].num));
            chk({nm, " rem"},    32'(cnt_rem), 32'(vt[i].rem));
            chk({nm, " asg_v"},  32'(asg_v),   32'(vt[i].av));
            chk({nm, " asg_id"}, 32'(asg_id),  32'(vt[i].aid));
            chk({nm, " done"},   32'(done),    32'(vt[i].done));
            chk({nm, " served"}, 32'(served),  32'(vt[i].served));
        end

        // Three back-to-back customers: 0 then 1, third waits for a finish
        do_reset();
        run("b2b c1", 1'b1, 1'b0, 1'b0, 4'h1, 4'h1, 1'b1);
        chk("b2b c1 asg_id", 32'(asg_id), 32'(2'd0));
        chk("b2b c1 busy",   32'(busy),   32'(2'b01));
        run("b2b c2", 1'b1, 1'b0, 1'b0, 4'h2, 4'h2, 1'b1);
        chk("b2b c2 asg_id", 32'(asg_id), 32'(2'd1));
        chk("b2b c2 busy",   32'(busy),   32'(2'b11));
        run("b2b c3", 1'b1, 1'b1, 1'b0, 4'h3, 4'h3, 1'b0);
        chk("b2b c3 asg_v",  32'(asg_v),   32'(1'b0));
        chk("b2b c3 done",   32'(done),    32'(2'b01));
        chk("b2b c3 busy",   32'(busy),    32'(2'b10));
        chk("b2b c3 rem",    32'(cnt_rem), 32'(8'h10));
        run("b2b c4", 1'b1, 1'b0, 1'b0, 4'h3, 4'h3, 1'b1);
        chk("b2b c4 asg_v",  32'(asg_v),   32'(1'b1));
        chk("b2b c4 asg_id", 32'(asg_id),  32'(2'd0));
        chk("b2b c4 num",    32'(cnt_num), 32'(8'h23));
        chk("b2b c4 rem",    32'(cnt_rem), 32'(8'h13));

        // Both counters finish on one tick
        do_reset();
        run("dual c1", 1'b1, 1'b0, 1'b0, 4'h1, 4'h1, 1'b1);
        run("dual c2", 1'b1, 1'b0, 1'b0, 4'h2, 4'h1, 1'b1);
        chk("dual rem", 32'(cnt_rem), 32'(8'h11));
        run("dual tick", 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
        chk("dual done",   32'(done),   32'(2'b11));
        chk("dual served", 32'(served), 32'(8'd2));
        chk("dual busy",   32'(busy),   32'(2'b00));
        run("dual after", 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        chk("dual after done", 32'(done), 32'(2'b00));

        // Reset asserted between edges while both counters are mid-service
        do_reset();
        run("mid c1", 1'b1, 1'b0, 1'b0, 4'h6, 4'h5, 1'b1);
        run("mid c2", 1'b1, 1'b0, 1'b0, 4'h8, 4'h5, 1'b1);
        run("mid t1", 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
        run("mid t2", 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
        chk("mid rem pre", 32'(cnt_rem), 32'(8'h33));
        en = 1'b1; tick = 1'b1; q_empty = 1'b0; q_num = 4'h1; q_time = 4'h1;
        rst = 1'b1;
        #1;
        chk("mid rst busy",   32'(busy),    32'(2'b00));
        chk("mid rst rem",    32'(cnt_rem), 32'(8'h00));
        chk("mid rst num",    32'(cnt_num), 32'(8'h00));
        chk("mid rst served", 32'(served),  32'(8'd0));
        chk("mid rst q_re",   32'(q_re),    32'(1'b0));
        @(posedge clk);
        #1;
        chk("mid rst done", 32'(done), 32'(2'b00));
        rst = 1'b0;
        run("mid post", 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
        chk("mid post done",   32'(done),   32'(2'b00));
        chk("mid post served", 32'(served), 32'(8'd0));
        chk("mid post busy",   32'(busy),   32'(2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_dispatch.md
COUNTER_DISPATCH -- requirements
Module: counter_dispatch

Interface
REQ-001 SHALL have parameter NCNT, default 2, meaning number of service counters (2..4).
REQ-002 SHALL have parameter DT_SZ, default 4, meaning width of customer number and service time.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  global run enable; 0 freezes all dispatch and countdown.
REQ-006 SHALL have port tick  input  1  one-cycle time-unit strobe that decrements service time.
REQ-007 SHALL have port q_empty  input  1  customer FIFO empty flag.
REQ-008 SHALL have port q_num  input  DT_SZ  customer number at FIFO head.
REQ-009 SHALL have port q_time  input  DT_SZ  service time at FIFO head.
REQ-010 SHALL have port q_re  output  1  FIFO pop, combinational, sampled by FIFO on the same edge.
REQ-011 SHALL have port busy  output  NCNT  per-counter busy flag.
REQ-012 SHALL have port cnt_num  output  NCNT*DT_SZ  packed customer number per counter (counter 0 in LSBs).
REQ-013 SHALL have port cnt_rem  output  NCNT*DT_SZ  packed remaining service time per counter.
REQ-014 SHALL have port asg_v  output  1  registered one-cycle pulse: a customer was assigned.
REQ-015 SHALL have port asg_id  output  2  index of counter assigned, valid with asg_v.
REQ-016 SHALL have port done  output  NCNT  registered one-cycle pulse per counter finishing service.
REQ-017 SHALL have port served  output  8  total customers completed, saturating at 255.

Function
REQ-018 Each counter SHALL be a 2-state FSM: IDLE (busy=0) and SERVE (busy=1).
REQ-019 q_re SHALL equal en & ~q_empty & (at least one counter IDLE); at most one pop per cycle.
REQ-020 On an edge with q_re=1 the selected counter SHALL enter SERVE with cnt_num=q_num, cnt_rem=q_time (q_time=0 loaded as 1).
REQ-021 Selection SHALL be round-robin: first IDLE counter at or after pointer rr (wrapping); then rr <= selected+1 mod NCNT.
REQ-022 asg_v/asg_id SHALL assert in the cycle after the loading edge.
REQ-023 On an edge with en & tick, every SERVE counter not being loaded on that edge SHALL decrement cnt_rem by 1.
REQ-024 A counter with cnt_rem=1 on such an edge SHALL go to IDLE with cnt_rem=0, keep cnt_num, and pulse its done bit next cycle.
REQ-025 A counter leaving SERVE on an edge SHALL be eligible for assignment from the following cycle, not the same edge.
REQ-026 Several counters finishing on one tick SHALL each pulse done simultaneously; served SHALL add the popcount of finishers, saturating.
REQ-027 With en=0, q_re SHALL be 0, cnt_rem frozen, asg_v and done held 0; tick ignored.
REQ-028 Dispatch SHALL be independent of tick: a customer is assigned on any cycle with q_re=1.

Reset
REQ-029 rst=1 SHALL immediately force all counters IDLE, cnt_num=0, cnt_rem=0, rr=0, asg_v=0, asg_id=0, done=0, served=0.
REQ-030 q_re SHALL be 0 while rst=1; reset mid-service SHALL discard in-progress customers with no done pulse.

Structure
REQ-031 Shared package SHALL hold DT_SZ default, NCNT maximum, and IDLE/SERVE state encodings.
REQ-032 Per-counter FSM plus countdown SHALL be sub-module counter_slot, instantiated NCNT times; arbitration and statistics in top level.

Verification
REQ-033 Reset then q_empty=0, q_num=5, q_time=3, NCNT=2 -> q_re=1 one cycle, counter 0 SERVE, asg_v with asg_id=0 next cycle.
REQ-034 Counter 0 serving rem=3, three ticks -> rem 2,1,0, done[0] pulses once after third tick, served=1.
REQ-035 Both counters idle, three customers queued back-to-back -> assigned to counters 0 then 1, third waits with q_re=0 until a done.
REQ-036 Both counters rem=1, single tick -> done=2'b11 same cycle, served increments by 2.
REQ-037 q_time=0 customer -> loaded rem=1, finishes on first tick.
REQ-038 rst asserted mid-service with en=1 -> busy=0 immediately, no done pulse, served=0; en=0 phase -> no pops, rem frozen.
